// File: rtl/signal_change_logger.sv
// signal_change_logger
// Watches CHANNELS buses for value changes and queues each change as a
// timestamped {time, channel, value} event in a small first-word-fall-through
// FIFO. Each channel holds at most one pending event. A newer change on the same
// channel overwrites an older event that has not yet been pushed, and that merge
// is counted. A stalled consumer therefore never stalls the observed system.
module signal_change_logger #(
   parameter int WIDTH       = 5,
   parameter int CHANNELS    = 2,
   parameter int DEPTH       = 8,
   parameter int TS_W        = 32,
   parameter int CNT_W       = 16,
   parameter int REPORT_INIT = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en_i,
   input  logic [CHANNELS*WIDTH-1:0]   mon_i,
   output logic                        evt_valid_o,
   input  logic                        evt_ready_i,
   output logic [$clog2(CHANNELS):0]   evt_chan_o,
   output logic [WIDTH-1:0]            evt_value_o,
   output logic [TS_W-1:0]             evt_time_o,
   output logic [$clog2(DEPTH):0]      level_o,
   output logic [CNT_W-1:0]            coalesced_o
);

   localparam int CH_W = $clog2(CHANNELS) + 1;
   localparam int AW   = $clog2(DEPTH);

   // free-running timestamp source
   logic [TS_W-1:0]     counter_reg;

   // per-channel observation and pending-event state
   logic [WIDTH-1:0]    mon_ch    [CHANNELS];
   logic [WIDTH-1:0]    prev_reg  [CHANNELS];
   logic                pend_reg  [CHANNELS];
   logic [WIDTH-1:0]    pval_reg  [CHANNELS];
   logic [TS_W-1:0]     ptime_reg [CHANNELS];
   logic [CHANNELS-1:0] chg;
   logic [CHANNELS-1:0] pushed_ch;
   logic [CHANNELS-1:0] coal;

   // arbiter
   logic [CH_W-1:0]     rr_reg;
   logic [CH_W-1:0]     rr_next;
   logic                sel_found;
   logic [CH_W-1:0]     sel_idx;
   logic [WIDTH-1:0]    sel_val;
   logic [TS_W-1:0]     sel_time;

   // event FIFO
   logic [CH_W-1:0]     mem_chan  [DEPTH];
   logic [WIDTH-1:0]    mem_value [DEPTH];
   logic [TS_W-1:0]     mem_time  [DEPTH];
   logic [AW-1:0]       wr_ptr_reg;
   logic [AW-1:0]       rd_ptr_reg;
   logic [AW:0]         count_reg;
   logic                full;
   logic                push_en;
   logic                pop_en;

   logic [CNT_W-1:0]    coalesced_reg;
   logic [CNT_W-1:0]    coalesced_next;

   // cycle counter, wraps naturally at 2^TS_W
   always_ff @(posedge clk) begin
      if (!rst_n) counter_reg <= '0;
      else        counter_reg <= counter_reg + TS_W'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         assign mon_ch[gi]    = mon_i[gi*WIDTH +: WIDTH];
         assign chg[gi]       = en_i && (mon_ch[gi] != prev_reg[gi]);
         assign pushed_ch[gi] = push_en && (sel_idx == CH_W'(gi));
         // a change merges into a pending event only if that event is not leaving this cycle
         assign coal[gi]      = chg[gi] && pend_reg[gi] && !pushed_ch[gi];

         // previous-value tracking and pending-event capture for one channel
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               prev_reg[gi]  <= (REPORT_INIT != 0) ? '0 : mon_ch[gi];
               pend_reg[gi]  <= 1'b0;
               pval_reg[gi]  <= '0;
               ptime_reg[gi] <= '0;
            end else begin
               prev_reg[gi] <= mon_ch[gi];
               if (chg[gi]) begin
                  pend_reg[gi]  <= 1'b1;
                  pval_reg[gi]  <= mon_ch[gi];
                  ptime_reg[gi] <= counter_reg;
               end else if (pushed_ch[gi]) begin
                  pend_reg[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // round-robin pick: scan from rr_reg upward, the lowest rotated offset wins
   always_comb begin
      logic [CH_W-1:0] cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_val   = '0;
      sel_time  = '0;
      cand      = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         cand = rr_reg + CH_W'(i);
         if (cand >= CH_W'(CHANNELS)) cand = cand - CH_W'(CHANNELS);
         for (int k = 0; k < CHANNELS; k++) begin
            if (pend_reg[k] && (cand == CH_W'(k))) begin
               sel_found = 1'b1;
               sel_idx   = cand;
               sel_val   = pval_reg[k];
               sel_time  = ptime_reg[k];
            end
         end
      end
   end

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign pop_en  = evt_valid_o && evt_ready_i;
   assign push_en = sel_found && (!full || pop_en);

   // next round-robin start is the channel after the one just pushed
   always_comb begin
      rr_next = rr_reg;
      if (push_en) begin
         if (sel_idx == CH_W'(CHANNELS - 1)) rr_next = '0;
         else                                rr_next = sel_idx + CH_W'(1);
      end
   end

   // saturating count of merged changes, one step per merging channel
   always_comb begin
      coalesced_next = coalesced_reg;
      for (int k = 0; k < CHANNELS; k++) begin
         if (coal[k] && (coalesced_next != '1)) coalesced_next = coalesced_next + CNT_W'(1);
      end
   end

   // arbiter and statistics state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_reg        <= '0;
         coalesced_reg <= '0;
      end else begin
         rr_reg        <= rr_next;
         coalesced_reg <= coalesced_next;
      end
   end

   // FIFO storage; contents need no reset because the outputs are gated by occupancy
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_chan[wr_ptr_reg]  <= sel_idx;
         mem_value[wr_ptr_reg] <= sel_val;
         mem_time[wr_ptr_reg]  <= sel_time;
      end
   end

   // FIFO pointers and occupancy; a push and pop in one cycle leave the level unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // head of FIFO falls through directly so an event is visible the cycle after its push
   assign evt_valid_o = (count_reg != '0);
   assign evt_chan_o  = evt_valid_o ? mem_chan[rd_ptr_reg]  : '0;
   assign evt_value_o = evt_valid_o ? mem_value[rd_ptr_reg] : '0;
   assign evt_time_o  = evt_valid_o ? mem_time[rd_ptr_reg]  : '0;
   assign level_o     = count_reg;
   assign coalesced_o = coalesced_reg;

endmodule
